// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and sizing helpers for the bit-serial subtractor
package serial_sub_pkg;

    localparam int WIDTH_MAX = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // A 1-bit operand still needs a 1-bit counter, hence the floor of 1.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for serial_subtractor (ovf under SERIAL_SUB_OVF_EN)
interface serial_subtractor_if #(parameter int WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - one-bit half subtractor, two of which form the per-bit full subtractor
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first, registered borrow; SERIAL_SUB_OVF_EN adds ovf
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             borrow_r;
    logic             d1;
    logic             bo1;
    logic             d_bit;
    logic             bo2;
    logic             bout;
    logic             last;
    logic             accept;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_out_r;

    half_subtractor u_hs_ab (.x(a_sr[0]), .y(b_sr[0]), .d(d1),    .bo(bo1));
    half_subtractor u_hs_bi (.x(d1),      .y(borrow_r), .d(d_bit), .bo(bo2));

    assign bout   = bo1 | bo2;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = bus.start && (state == ST_IDLE || state == ST_DONE);

    // Result fills from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = d_bit;
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            a_msb_r <= bus.a[WIDTH-1];
            b_msb_r <= bus.b[WIDTH-1];
        end else if (state == ST_RUN && last) begin
            ovf_r   <= (a_msb_r ^ b_msb_r) & (d_bit ^ a_msb_r);
        end
    end

    assign bus.ovf = ovf_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            a_sr         <= '0;
            b_sr         <= '0;
            res_sr       <= '0;
            cnt          <= '0;
            borrow_r     <= 1'b0;
            done_r       <= 1'b0;
            diff_r       <= '0;
            borrow_out_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                a_sr     <= bus.a;
                b_sr     <= bus.b;
                res_sr   <= '0;
                cnt      <= '0;
                borrow_r <= 1'b0;
                state    <= ST_RUN;
            end else if (state == ST_RUN) begin
                a_sr     <= a_sr >> 1;
                b_sr     <= b_sr >> 1;
                res_sr   <= res_next;
                borrow_r <= bout;
                cnt      <= cnt + CW'(1);
                if (last) begin
                    diff_r       <= res_next;
                    borrow_out_r <= bout;
                    done_r       <= 1'b1;
                    state        <= ST_DONE;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    assign bus.busy   = (state == ST_RUN);
    assign bus.done   = done_r;
    assign bus.diff   = diff_r;
    assign bus.borrow = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed checks of serial_subtractor at WIDTH 8 and 1
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain two's-complement arithmetic on integers, independent of any bit-serial detail.
    task automatic model(input int w, input longint a, input longint b,
                         output longint d, output bit bo, output bit ov);
        longint m, sa, sb, sd;
        m  = longint'(1) << w;
        d  = a - b;
        if (d < 0) d += m;
        bo = (a < b);
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        sd = sa - sb;
        ov = (sd >= m / 2) || (sd < -(m / 2));
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int repulse_at, input string tag);
        longint    ed;
        bit        eb, eo;
        int        lat, busy_cnt, dones;
        bit        stable;
        logic [7:0] prev_diff, got_diff;
        logic      prev_borrow, got_borrow, got_ovf;
        model(8, a, b, ed, eb, eo);
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.start = 1'b1;
        prev_diff = bus8.diff; prev_borrow = bus8.borrow;
        lat = -1; busy_cnt = 0; dones = 0; stable = 1'b1;
        got_diff = 'x; got_borrow = 1'bx; got_ovf = 1'bx;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            end
            if (k == repulse_at) begin
                bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00;
            end
            if (k == repulse_at + 1) bus8.start = 1'b0;
            if (bus8.busy) busy_cnt++;
            if (bus8.done) begin
                dones++;
                if (lat < 0) begin
                    lat = k; got_diff = bus8.diff; got_borrow = bus8.borrow;
`ifdef SERIAL_SUB_OVF_EN
                    got_ovf = bus8.ovf;
`endif
                end
            end else if (lat < 0 && (bus8.diff !== prev_diff || bus8.borrow !== prev_borrow)) begin
                stable = 1'b0;
            end
        end
        check({tag, ".latency"}, 64'(lat), 64'd8);
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd8);
        check({tag, ".done_pulses"}, 64'(dones), 64'd1);
        check({tag, ".hold_during_run"}, 64'(stable), 64'd1);
        check({tag, ".diff"}, 64'(got_diff), 64'(ed));
        check({tag, ".borrow"}, 64'(got_borrow), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, ".ovf"}, 64'(got_ovf), 64'(eo));
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, 64'(bus8.busy), 64'd0);
        check({tag, ".done"}, 64'(bus8.done), 64'd0);
        check({tag, ".diff"}, 64'(bus8.diff), 64'd0);
        check({tag, ".borrow"}, 64'(bus8.borrow), 64'd0);
        check({tag, ".w1_diff"}, 64'(bus1.diff), 64'd0);
        check({tag, ".w1_borrow"}, 64'(bus1.borrow), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, ".ovf"}, 64'(bus8.ovf), 64'd0);
`endif
    endtask

    initial begin
        logic [0:0] a1 [4];
        logic [0:0] b1 [4];
        int         idx, dones;
        bit         seen_done;
        longint     ed;
        bit         eb, eo;

        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        op8(8'd5,    8'd3,    -10, "sub_5_3");
        op8(8'd3,    8'd5,    -10, "sub_3_5");
        op8(8'h80,   8'h01,   -10, "sub_80_01");
        op8(8'h5A,   8'hC3,   3,   "ignored_restart");
        op8(8'h00,   8'h00,   -10, "sub_0_0");
        op8(8'hFF,   8'hFF,   -10, "sub_ff_ff");
        op8(8'h00,   8'hFF,   -10, "sub_0_ff");
        op8(8'h7F,   8'h80,   -10, "sub_7f_80");
        for (int i = 0; i < 16; i++)
            op8(8'($urandom), 8'($urandom), -10, $sformatf("rand%0d", i));

        // Abort mid-operation with a previously non-zero result on the outputs.
        op8(8'h01, 8'h02, -10, "pre_abort");
        @(negedge clk);
        bus8.a = 8'h37; bus8.b = 8'h11; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("async_abort");
        seen_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.done) seen_done = 1'b1;
        end
        check("abort.no_done", 64'(seen_done), 64'd0);
        check("abort.diff_cleared", 64'(bus8.diff), 64'd0);
        op8(8'h10, 8'h10, -10, "after_reset");

        // WIDTH=1, operands re-offered on every done so each accept happens in DONE.
        a1 = '{1'b0, 1'b0, 1'b1, 1'b1};
        b1 = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        bus1.a = a1[0]; bus1.b = b1[0]; bus1.start = 1'b1;
        idx = 0; dones = 0;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            @(negedge clk);
            if (bus1.done) begin
                dones++;
                model(1, longint'(a1[idx]), longint'(b1[idx]), ed, eb, eo);
                check($sformatf("w1_pair%0d.cycle", idx), 64'(k), 64'(2 * idx + 1));
                check($sformatf("w1_pair%0d.diff", idx), 64'(bus1.diff), 64'(ed));
                check($sformatf("w1_pair%0d.borrow", idx), 64'(bus1.borrow), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
                check($sformatf("w1_pair%0d.ovf", idx), 64'(bus1.ovf), 64'(eo));
`endif
                idx++;
                if (idx < 4) begin
                    bus1.a = a1[idx]; bus1.b = b1[idx]; bus1.start = 1'b1;
                end else begin
                    bus1.start = 1'b0;
                end
            end else begin
                bus1.start = 1'b0;
            end
        end
        check("w1.results_seen", 64'(dones), 64'd4);
        repeat (3) @(negedge clk);
        check("w1.idle_after", 64'(bus1.busy | bus1.done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
